// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution controller.
// Optional feature macro: BRANCH_CTRL_BHT_EN (dynamic BHT prediction).
package branch_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } bctrl_state_t;

  // 2-bit counters start weakly not-taken.
  localparam logic [1:0] BHT_RESET = 2'b01;
  localparam logic [1:0] BHT_MAX   = 2'b11;
  localparam logic [1:0] BHT_MIN   = 2'b00;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } redirect_t;

endpackage

// File: rtl/branch_bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port and one synchronous update port.
// Instantiated by branch_ctrl only when BRANCH_CTRL_BHT_EN is defined.
module branch_bht
  import branch_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(ENTRIES)-1:0] rd_idx,
  output logic                       rd_taken,
  input  logic                       wr_en,
  input  logic [$clog2(ENTRIES)-1:0] wr_idx,
  input  logic                       wr_taken
);

  logic [1:0] ctr_q [ENTRIES];
  logic [1:0] ctr_d [ENTRIES];

  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
    if (taken) return (c == BHT_MAX) ? c : c + 2'd1;
    else       return (c == BHT_MIN) ? c : c - 2'd1;
  endfunction

  // Read returns the registered value, so a same-cycle update is not bypassed.
  assign rd_taken = ctr_q[rd_idx][1];

  // Next-state of the counter array: only the written entry moves.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) ctr_d[i] = ctr_q[i];
    if (wr_en) ctr_d[wr_idx] = sat_update(ctr_q[wr_idx], wr_taken);
  end

  // Counter storage, reset to weakly not-taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= BHT_RESET;
    end else begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= ctr_d[i];
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: resolves EX-stage branches, issues a
// registered PC redirect plus a multi-cycle flush on mispredict, and keeps
// branch/mispredict statistics.
// Optional feature macro: BRANCH_CTRL_BHT_EN. When defined, a 2-bit BHT
// provides dynamic prediction; otherwise prediction is static not-taken.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_pc,
  output logic        id_pred_taken,
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic        cmp_out,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int              CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  bctrl_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  redirect_t        redir_q, redir_d;
  logic [31:0]      br_count_q, br_count_d;
  logic [31:0]      mispred_count_q, mispred_count_d;
  logic             res, mis;

  // Branches seen while flushing are wrong-path and never resolve.
  assign res = ex_valid & ex_branch & (state_q == IDLE);

`ifdef BRANCH_CTRL_BHT_EN
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  branch_bht #(
    .ENTRIES(BHT_ENTRIES)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (id_pc[IDX_W+1:2]),
    .rd_taken (id_pred_taken),
    .wr_en    (res),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_taken (cmp_out)
  );

  assign mis = res & (cmp_out != ex_pred_taken);
`else
  // Static not-taken: any taken branch is a mispredict.
  assign id_pred_taken = 1'b0;
  assign mis           = res & cmp_out;
`endif

  // Inputs only partly consumed depending on configuration.
  logic unused_inputs;
  assign unused_inputs = ^{id_pc, ex_pred_taken};

  // Next-state: FSM, flush down-counter, redirect and statistics.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    redir_d.valid   = mis;
    redir_d.pc      = redir_q.pc;
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;

    case (state_q)
      IDLE: begin
        if (mis) begin
          state_d = FLUSH;
          cnt_d   = CNT_LOAD;
        end
      end
      FLUSH: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    if (mis) redir_d.pc = cmp_out ? ex_target : ex_pc + 32'd4;
    if (res) br_count_d = br_count_q + 32'd1;
    if (mis) mispred_count_d = mispred_count_q + 32'd1;
  end

  // Control and output registers; reset clears any pending redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      redir_q         <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      redir_q         <= redir_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign redirect_valid = redir_q.valid;
  assign redirect_pc    = redir_q.pc;
  assign flush          = (state_q == FLUSH);
  assign br_count       = br_count_q;
  assign mispred_count  = mispred_count_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios followed by
// random traffic, checked against a cycle-level reference model.
// Follows BRANCH_CTRL_BHT_EN so the model matches the built configuration.
module tb_branch_ctrl;

  localparam int BHT_ENTRIES  = 16;
  localparam int FLUSH_CYCLES = 2;
`ifdef BRANCH_CTRL_BHT_EN
  localparam bit BHT_EN = 1'b1;
`else
  localparam bit BHT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_pc;
  logic        id_pred_taken;
  logic        ex_valid, ex_branch, ex_pred_taken, cmp_out;
  logic [31:0] ex_pc, ex_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] br_count, mispred_count;

  always #5 clk = ~clk;

  branch_ctrl #(
    .BHT_ENTRIES (BHT_ENTRIES),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_pc         (id_pc),
    .id_pred_taken (id_pred_taken),
    .ex_valid      (ex_valid),
    .ex_branch     (ex_branch),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .ex_pred_taken (ex_pred_taken),
    .cmp_out       (cmp_out),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .flush         (flush),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  int          m_bht [BHT_ENTRIES];
  int          m_flush_left;
  logic [31:0] m_br, m_mp;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int bht_idx(input logic [31:0] pc);
    return int'((pc >> 2) % BHT_ENTRIES);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BHT_ENTRIES; i++) m_bht[i] = 1;
    m_flush_left = 0;
    m_br = 0;
    m_mp = 0;
    exp_q.delete();
  endtask

  // One clock cycle: drive inputs, check visible state, advance the model.
  task automatic step(input logic v, input logic b, input logic [31:0] pc,
                      input logic [31:0] tgt, input logic pred, input logic cmp,
                      input logic [31:0] ipc);
    bit res, mis;
    @(posedge clk);
    #1;
    ex_valid = v; ex_branch = b; ex_pc = pc; ex_target = tgt;
    ex_pred_taken = pred; cmp_out = cmp; id_pc = ipc;
    #2;
    chk("flush", {31'd0, flush}, {31'd0, m_flush_left > 0});
    chk("br_count", br_count, m_br);
    chk("mispred_count", mispred_count, m_mp);
    chk("id_pred_taken", {31'd0, id_pred_taken},
        {31'd0, BHT_EN && (m_bht[bht_idx(ipc)] >= 2)});
    res = v && b && (m_flush_left == 0);
    mis = res && (BHT_EN ? (cmp != pred) : cmp);
    if (m_flush_left > 0) m_flush_left--;
    if (res) begin
      m_br++;
      if (cmp) m_bht[bht_idx(pc)] = (m_bht[bht_idx(pc)] == 3) ? 3 : m_bht[bht_idx(pc)] + 1;
      else     m_bht[bht_idx(pc)] = (m_bht[bht_idx(pc)] == 0) ? 0 : m_bht[bht_idx(pc)] - 1;
    end
    if (mis) begin
      m_mp++;
      m_flush_left = FLUSH_CYCLES;
      exp_q.push_back('{cyc: cyc + 1, pc: cmp ? tgt : pc + 32'd4});
    end
  endtask

  task automatic idle(input logic [31:0] ipc);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, ipc);
  endtask

  // Branch in EX followed by enough idle cycles to leave any flush.
  task automatic branch(input logic [31:0] pc, input logic [31:0] tgt,
                        input logic pred, input logic cmp);
    step(1'b1, 1'b1, pc, tgt, pred, cmp, pc);
    for (int i = 0; i < FLUSH_CYCLES + 1; i++) idle(pc);
  endtask

  // Redirect monitor: every redirect pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_redirect: got pc %h expected no redirect (cycle %0d)",
                 redirect_pc, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("redirect_cycle", cyc, e.cyc);
        chk("redirect_pc", redirect_pc, e.pc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    ex_valid = 0; ex_branch = 0; ex_pc = 0; ex_target = 0;
    ex_pred_taken = 0; cmp_out = 0; id_pc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_br_count", br_count, 32'd0);
    chk("rst_mispred_count", mispred_count, 32'd0);
    chk("rst_id_pred", {31'd0, id_pred_taken}, 32'd0);
    rst = 1'b0;

    idle(32'h0);
    idle(32'h3C);
    idle(32'hFFFF_FFFC);

    // Taken mispredict, then a wrong-path branch during the flush
    step(1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 1'b1, 32'h100);
    step(1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 1'b1, 32'h100);
    idle(32'h100);
    idle(32'h100);
    chk("br_after_flush", br_count, 32'd1);
    chk("mp_after_flush", mispred_count, 32'd1);

    // Not-taken branch predicted taken
    branch(32'h200, 32'h300, 1'b1, 1'b0);

    // Train 0x100 taken, check aliasing entry 0x140
    branch(32'h100, 32'h80, 1'b1, 1'b1);
    branch(32'h100, 32'h80, 1'b1, 1'b1);
    idle(32'h140);

    // Saturate, then one not-taken; prediction should stay taken
    for (int i = 0; i < 4; i++) branch(32'h100, 32'h80, 1'b1, 1'b1);
    branch(32'h100, 32'h80, 1'b1, 1'b0);
    idle(32'h100);

    // Fall-through address wraps past the top of memory
    branch(32'hFFFF_FFFC, 32'h40, 1'b1, 1'b0);

    // Reset asserted in the middle of a flush
    step(1'b1, 1'b1, 32'h180, 32'h20, 1'b0, 1'b1, 32'h180);
    idle(32'h180);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_flush", {31'd0, flush}, 32'd0);
    chk("midrst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("midrst_redirect_pc", redirect_pc, 32'd0);
    chk("midrst_br_count", br_count, 32'd0);
    chk("midrst_id_pred", {31'd0, id_pred_taken}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(32'h100);
    idle(32'h100);

    // Random traffic over a small PC pool so BHT entries alias
    for (int i = 0; i < 600; i++) begin
      logic [31:0] pc, ipc, tgt;
      logic v, b, pred, cmp;
      pc   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      ipc  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      tgt  = $urandom;
      v    = ($urandom_range(0, 3) != 0);
      b    = 1'($urandom_range(0, 1));
      pred = 1'($urandom_range(0, 1));
      cmp  = b & 1'($urandom_range(0, 1));
      step(v, b, pc, tgt, pred, cmp, ipc);
    end
    for (int i = 0; i < FLUSH_CYCLES + 2; i++) idle(32'h0);

    chk("redirects_outstanding", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
